uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_send` transmitter among `N_REQ` byte producers. It accepts a byte from one requester at a time and issues a single-cycle `valid` pulse with the byte to the transmitter. It then blocks further issues until one full UART frame (start + 8 data + stop) has elapsed. It sits between the application sources (key scanner, status reporter, echo path, …) and the `uart_send` instance in the top level.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
// Frame length counts the start bit, eight data bits and the stop bit.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 10416;
   localparam int FRAME_BITS       = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_t;

   function automatic int frame_cycles(input int clks_per_bit, input int guard);
      return FRAME_BITS * clks_per_bit + guard;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N_REQ, plus an any-request flag.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] winner,
   output logic                     any_valid
);

   localparam int PW = $clog2(N_REQ);

   logic [PW:0]      sum [N_REQ];
   logic [PW-1:0]    idx [N_REQ];
   logic [N_REQ-1:0] rot;

   // rot[k] is the request that sits k positions after the pointer
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign sum[gi] = {1'b0, ptr} + (PW+1)'(gi);
         assign idx[gi] = (sum[gi] >= (PW+1)'(N_REQ)) ?
                          PW'(sum[gi] - (PW+1)'(N_REQ)) : sum[gi][PW-1:0];
         assign rot[gi] = req_valid[idx[gi]];
      end
   endgenerate

   always_comb begin
      winner = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) winner = idx[k];
      end
   end

   assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler feeding one UART transmitter: one byte per grant,
// then holds off further grants for a full frame plus a guard interval.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int GUARD        = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [8*N_REQ-1:0]       req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);

   localparam int PW           = $clog2(N_REQ);
   localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, GUARD);
   localparam int CNT_W        = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

   arb_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [PW-1:0]    ptr_reg, ptr_next;
   logic [N_REQ-1:0] req_ready_reg, req_ready_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic             tx_valid_reg, tx_valid_next;
   logic [PW-1:0]    grant_id_reg, grant_id_next;

   logic [PW-1:0]    winner;
   logic             any_valid;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_valid (req_valid),
      .ptr       (ptr_reg),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         ptr_reg       <= '0;
         req_ready_reg <= '0;
         tx_data_reg   <= '0;
         tx_valid_reg  <= 1'b0;
         grant_id_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ptr_reg       <= ptr_next;
         req_ready_reg <= req_ready_next;
         tx_data_reg   <= tx_data_next;
         tx_valid_reg  <= tx_valid_next;
         grant_id_reg  <= grant_id_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ptr_next       = ptr_reg;
      req_ready_next = '0;
      tx_data_next   = tx_data_reg;
      tx_valid_next  = 1'b0;
      grant_id_next  = grant_id_reg;

      case (state_reg)
         ST_IDLE: begin
            if (any_valid) begin
               state_next     = ST_WAIT;
               cnt_next       = CNT_LOAD;
               tx_valid_next  = 1'b1;
               req_ready_next = N_REQ'(1) << winner;
               tx_data_next   = req_data[{winner, 3'b000} +: 8];
               grant_id_next  = winner;
               ptr_next       = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
            end
         end
         ST_WAIT: begin
            // Requests are ignored here; they are re-examined once back in IDLE
            if (cnt_reg == '0) begin
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
      endcase
   end

   assign req_ready = req_ready_reg;
   assign tx_data   = tx_data_reg;
   assign tx_valid  = tx_valid_reg;
   assign grant_id  = grant_id_reg;
   assign busy      = (state_reg == ST_WAIT);

endmodule
